ddr3_app_arbiter: RTL and testbench

DDR3_APP_ARBITER -- requirements
Module: ddr3_app_arbiter

---
 rtl/ddr3_app_arbiter_pkg.sv | 9 +
 rtl/ddr3_app_arbiter_if.sv | 39 +++
 rtl/ddr3_app_arbiter.sv | 69 ++++++
 tb/tb_ddr3_app_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_app_arbiter_pkg.sv
// ddr3_app_arbiter_pkg: shared state encodings, MIG command codes and default widths
package ddr3_app_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;
  localparam int ADDR_W_DEF = 29;
  localparam int LEN_W_DEF = 8;
  localparam int ADDR_STEP_DEF = 8;
endpackage

// File: rtl/ddr3_app_arbiter_if.sv
// ddr3_app_arbiter_if: user burst requests on one side, MIG app command/handshake on the other
interface ddr3_app_arbiter_if
  import ddr3_app_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) ();
  logic init_calib_complete;
  logic wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [LEN_W-1:0] wr_len;
  logic wr_data_rd;
  logic wr_done;
  logic rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0] rd_len;
  logic rd_data_valid;
  logic rd_done;
  logic [ADDR_W-1:0] app_addr;
  logic [2:0] app_cmd;
  logic app_en;
  logic app_wdf_wren;
  logic app_wdf_end;
  logic app_rdy;
  logic app_wdf_rdy;
  logic app_rd_data_valid;
  modport master (
    input init_calib_complete, wr_req, wr_addr, wr_len, rd_req, rd_addr, rd_len,
          app_rdy, app_wdf_rdy, app_rd_data_valid,
    output wr_data_rd, wr_done, rd_data_valid, rd_done,
           app_addr, app_cmd, app_en, app_wdf_wren, app_wdf_end
  );
  modport slave (
    output init_calib_complete, wr_req, wr_addr, wr_len, rd_req, rd_addr, rd_len,
           app_rdy, app_wdf_rdy, app_rd_data_valid,
    input wr_data_rd, wr_done, rd_data_valid, rd_done,
          app_addr, app_cmd, app_en, app_wdf_wren, app_wdf_end
  );
endinterface

// File: rtl/ddr3_app_arbiter.sv
// ddr3_app_arbiter: round-robin write/read burst arbiter driving the MIG app command port
module ddr3_app_arbiter
  import ddr3_app_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int ADDR_STEP = ADDR_STEP_DEF
) (
  input logic ui_clk,
  input logic ui_rst_n,
  ddr3_app_arbiter_if.master bus
);
  logic [1:0] rst_sync;
  logic rst_n_s;
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0] beats;
  logic [LEN_W:0] outst;
  logic last_rd, have, grant_wr, grant_rd, wr_go, cmd_rd, ret, wr_done, rd_done;
  // reset asserts asynchronously, releases two clocks later in ui_clk domain
  always_ff @(posedge ui_clk or negedge ui_rst_n)
    if (!ui_rst_n) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n_s = rst_sync[1];
  // grant decision, beat acceptance and next state
  always_comb begin
    have = beats != '0;
    grant_wr = state == IDLE && bus.init_calib_complete && bus.wr_req && (!bus.rd_req || last_rd);
    grant_rd = state == IDLE && bus.init_calib_complete && bus.rd_req && !grant_wr;
    wr_go = state == WRITE && bus.app_rdy && bus.app_wdf_rdy && have;
    cmd_rd = state == READ && bus.app_rdy && have;
    ret = bus.app_rd_data_valid && outst != '0;
    wr_done = state == WRITE && !have;
    rd_done = outst == '0 && ((state == READ && !have) || state == DRAIN);
    state_nx = grant_wr ? WRITE :
               grant_rd ? READ :
               (wr_done || rd_done) ? IDLE :
               (state == READ && !have) ? DRAIN : state;
  end
  assign bus.app_en = wr_go || cmd_rd;
  assign bus.app_wdf_wren = wr_go;
  assign bus.app_wdf_end = wr_go;
  assign bus.wr_data_rd = wr_go;
  assign bus.wr_done = wr_done;
  assign bus.rd_done = rd_done;
  assign bus.app_cmd = state == WRITE ? CMD_WR : CMD_RD;
  assign bus.app_addr = state == IDLE ? '0 : addr_q;
  assign bus.rd_data_valid = bus.app_rd_data_valid && rst_n_s;
  // state, burst address/length latch and outstanding-read count
  always_ff @(posedge ui_clk or negedge rst_n_s)
    if (!rst_n_s) begin
      state <= IDLE;
      addr_q <= '0;
      beats <= '0;
      outst <= '0;
      last_rd <= 1'b1;
    end else begin
      state <= state_nx;
      if (grant_wr || grant_rd) begin
        addr_q <= grant_wr ? bus.wr_addr : bus.rd_addr;
        beats <= grant_wr ? bus.wr_len : bus.rd_len;
        last_rd <= grant_rd;
      end else if (bus.app_en) begin
        addr_q <= addr_q + ADDR_W'(ADDR_STEP);
        beats <= beats - LEN_W'(1);
      end
      outst <= outst + {{LEN_W{1'b0}}, cmd_rd} - {{LEN_W{1'b0}}, ret};
    end
endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// tb_ddr3_app_arbiter: table-driven burst vectors plus hand sequences for arbitration and corner cases
module tb_ddr3_app_arbiter;
  import ddr3_app_arbiter_pkg::*;
  logic ui_clk = 1'b0;
  logic ui_rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  ddr3_app_arbiter_if #(.ADDR_W(29), .LEN_W(8)) bus ();
  ddr3_app_arbiter #(.ADDR_W(29), .LEN_W(8), .ADDR_STEP(8)) dut (
    .ui_clk(ui_clk),
    .ui_rst_n(ui_rst_n),
    .bus(bus)
  );
  always #5 ui_clk = ~ui_clk;
  typedef struct {
    logic wr, rd, rdy, dv, en, wd, rdn, ca;
    logic [2:0] cmd;
    logic [28:0] addr;
  } vec_t;
  vec_t tv[$];
  function automatic vec_t mk(input logic [7:0] f, input logic [2:0] cmd, input logic [28:0] addr);
    vec_t v;
    {v.wr, v.rd, v.rdy, v.dv, v.en, v.wd, v.rdn, v.ca} = f;
    v.cmd = cmd;
    v.addr = addr;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge ui_clk);
    #1;
  endtask
  task automatic wait_done(input logic wr, input string nm);
    int n = 0;
    while ((wr ? bus.wr_done : bus.rd_done) !== 1'b1 && n < 40) begin
      @(negedge ui_clk);
      n++;
    end
    chk(nm, wr ? bus.wr_done : bus.rd_done, 1);
  endtask
  task automatic write_finish(input string nm);
    wait_done(1'b1, nm);
    cyc();
    bus.wr_req = 0;
  endtask
  task automatic read_finish(input string nm);
    cyc();
    bus.app_rd_data_valid = 1;
    cyc();
    bus.app_rd_data_valid = 0;
    wait_done(1'b0, nm);
    cyc();
    bus.rd_req = 0;
  endtask
  task automatic do_reset();
    ui_rst_n = 0;
    bus.init_calib_complete = 1;
    bus.wr_req = 0;
    bus.rd_req = 0;
    bus.app_rdy = 1;
    bus.app_wdf_rdy = 1;
    bus.app_rd_data_valid = 1;
    repeat (2) @(negedge ui_clk);
    chk("rst_app_en", bus.app_en, 0);
    chk("rst_app_cmd", bus.app_cmd, CMD_RD);
    chk("rst_app_addr", bus.app_addr, 0);
    chk("rst_wdf_wren", bus.app_wdf_wren, 0);
    chk("rst_wdf_end", bus.app_wdf_end, 0);
    chk("rst_wr_data_rd", bus.wr_data_rd, 0);
    chk("rst_wr_done", bus.wr_done, 0);
    chk("rst_rd_done", bus.rd_done, 0);
    chk("rst_rd_data_valid", bus.rd_data_valid, 0);
    bus.app_rd_data_valid = 0;
    cyc();
    ui_rst_n = 1;
    repeat (3) cyc();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end
  initial begin
    logic wx;
    bus.wr_addr = 0;
    bus.wr_len = 0;
    bus.rd_addr = 0;
    bus.rd_len = 0;
    tv.push_back(mk(8'b1010_0001, CMD_RD, 29'h0));
    for (int k = 0; k < 8; k++) tv.push_back(mk(8'b1010_1001, CMD_WR, 29'(8 * k)));
    tv.push_back(mk(8'b1010_0100, CMD_WR, 29'h0));
    tv.push_back(mk(8'b0010_0001, CMD_RD, 29'h0));
    tv.push_back(mk(8'b0100_0001, CMD_RD, 29'h0));
    for (int k = 0; k < 4; k++) begin
      tv.push_back(mk(8'b0110_1001, CMD_RD, 29'h100 + 29'(8 * k)));
      tv.push_back(mk(8'b0100_0001, CMD_RD, 29'h108 + 29'(8 * k)));
    end
    for (int j = 9; j < 18; j++)
      tv.push_back(mk((j % 2 == 1 && j >= 11) ? 8'b0111_0000 : 8'b0110_0000, CMD_RD, 29'h0));
    tv.push_back(mk(8'b0110_0010, CMD_RD, 29'h0));
    tv.push_back(mk(8'b0010_0001, CMD_RD, 29'h0));
    do_reset();
    bus.wr_addr = 0;
    bus.wr_len = 8;
    bus.rd_addr = 29'h100;
    bus.rd_len = 4;
    foreach (tv[i]) begin
      bus.wr_req = tv[i].wr;
      bus.rd_req = tv[i].rd;
      bus.app_rdy = tv[i].rdy;
      bus.app_wdf_rdy = tv[i].rdy;
      bus.app_rd_data_valid = tv[i].dv;
      @(negedge ui_clk);
      wx = tv[i].en && tv[i].cmd == CMD_WR;
      chk($sformatf("v%0d_app_en", i), bus.app_en, tv[i].en);
      chk($sformatf("v%0d_wdf_wren", i), bus.app_wdf_wren, wx);
      chk($sformatf("v%0d_wdf_end", i), bus.app_wdf_end, wx);
      chk($sformatf("v%0d_wr_data_rd", i), bus.wr_data_rd, wx);
      chk($sformatf("v%0d_wr_done", i), bus.wr_done, tv[i].wd);
      chk($sformatf("v%0d_rd_done", i), bus.rd_done, tv[i].rdn);
      chk($sformatf("v%0d_app_cmd", i), bus.app_cmd, tv[i].cmd);
      chk($sformatf("v%0d_rd_data_valid", i), bus.rd_data_valid, tv[i].dv);
      if (tv[i].ca) chk($sformatf("v%0d_app_addr", i), bus.app_addr, tv[i].addr);
      cyc();
    end
    bus.app_rdy = 1;
    bus.app_wdf_rdy = 1;
    bus.app_rd_data_valid = 0;
    do_reset();
    bus.wr_addr = 29'h40;
    bus.wr_len = 1;
    bus.rd_addr = 29'h80;
    bus.rd_len = 1;
    bus.wr_req = 1;
    bus.rd_req = 1;
    cyc();
    @(negedge ui_clk);
    chk("tie1_first_cmd", bus.app_cmd, CMD_WR);
    chk("tie1_first_en", bus.app_en, 1);
    chk("tie1_first_addr", bus.app_addr, 29'h40);
    write_finish("tie1_wr_done");
    cyc();
    @(negedge ui_clk);
    chk("tie1_second_cmd", bus.app_cmd, CMD_RD);
    chk("tie1_second_en", bus.app_en, 1);
    chk("tie1_second_addr", bus.app_addr, 29'h80);
    read_finish("tie1_rd_done");
    bus.wr_req = 1;
    write_finish("solo_wr_done");
    bus.wr_req = 1;
    bus.rd_req = 1;
    cyc();
    @(negedge ui_clk);
    chk("tie2_first_cmd", bus.app_cmd, CMD_RD);
    chk("tie2_first_en", bus.app_en, 1);
    chk("tie2_first_addr", bus.app_addr, 29'h80);
    read_finish("tie2_rd_done");
    cyc();
    @(negedge ui_clk);
    chk("tie2_second_cmd", bus.app_cmd, CMD_WR);
    chk("tie2_second_en", bus.app_en, 1);
    write_finish("tie2_wr_done");
    bus.wr_addr = 29'h1FFFFFF8;
    bus.wr_len = 2;
    bus.wr_req = 1;
    cyc();
    @(negedge ui_clk);
    chk("wrap_addr0", bus.app_addr, 29'h1FFFFFF8);
    chk("wrap_en0", bus.app_en, 1);
    cyc();
    @(negedge ui_clk);
    chk("wrap_addr1", bus.app_addr, 29'h0);
    chk("wrap_en1", bus.app_en, 1);
    write_finish("wrap_wr_done");
    bus.init_calib_complete = 0;
    bus.wr_addr = 29'h500;
    bus.wr_len = 2;
    bus.wr_req = 1;
    repeat (3) cyc();
    @(negedge ui_clk);
    chk("calib_hold_en", bus.app_en, 0);
    chk("calib_hold_cmd", bus.app_cmd, CMD_RD);
    bus.init_calib_complete = 1;
    cyc();
    @(negedge ui_clk);
    chk("calib_grant_en", bus.app_en, 1);
    chk("calib_grant_addr", bus.app_addr, 29'h500);
    bus.init_calib_complete = 0;
    cyc();
    @(negedge ui_clk);
    chk("calib_mid_en", bus.app_en, 1);
    chk("calib_mid_addr", bus.app_addr, 29'h508);
    write_finish("calib_wr_done");
    bus.init_calib_complete = 1;
    bus.wr_len = 0;
    bus.wr_req = 1;
    @(negedge ui_clk);
    chk("len0w_grant_en", bus.app_en, 0);
    cyc();
    @(negedge ui_clk);
    chk("len0w_done", bus.wr_done, 1);
    chk("len0w_en", bus.app_en, 0);
    chk("len0w_wren", bus.app_wdf_wren, 0);
    cyc();
    bus.wr_req = 0;
    @(negedge ui_clk);
    chk("len0w_done_pulse", bus.wr_done, 0);
    bus.rd_len = 0;
    bus.rd_req = 1;
    cyc();
    @(negedge ui_clk);
    chk("len0r_done", bus.rd_done, 1);
    chk("len0r_en", bus.app_en, 0);
    cyc();
    bus.rd_req = 0;
    @(negedge ui_clk);
    chk("len0r_done_pulse", bus.rd_done, 0);
    bus.wr_addr = 29'h200;
    bus.wr_len = 8;
    bus.wr_req = 1;
    repeat (2) cyc();
    @(negedge ui_clk);
    chk("rstmid_pre_en", bus.app_en, 1);
    chk("rstmid_pre_addr", bus.app_addr, 29'h208);
    ui_rst_n = 0;
    #1;
    chk("rstmid_en", bus.app_en, 0);
    chk("rstmid_wren", bus.app_wdf_wren, 0);
    chk("rstmid_wr_data_rd", bus.wr_data_rd, 0);
    chk("rstmid_cmd", bus.app_cmd, CMD_RD);
    chk("rstmid_addr", bus.app_addr, 0);
    chk("rstmid_wr_done", bus.wr_done, 0);
    bus.wr_req = 0;
    repeat (2) cyc();
    ui_rst_n = 1;
    repeat (3) cyc();
    @(negedge ui_clk);
    chk("post_rst_en", bus.app_en, 0);
    chk("post_rst_addr", bus.app_addr, 0);
    chk("post_rst_wr_done", bus.wr_done, 0);
    bus.wr_addr = 29'h300;
    bus.wr_len = 1;
    bus.wr_req = 1;
    cyc();
    @(negedge ui_clk);
    chk("post_rst_wr_en", bus.app_en, 1);
    chk("post_rst_wr_addr", bus.app_addr, 29'h300);
    write_finish("post_rst_wr_done");
    repeat (2) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
